// File: rtl/accel_job_master_if.sv
// Wishbone classic bus between accel_job_master (master) and the accelerator slave port.
interface accel_job_master_if;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;

   modport master (
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
      input  wbm_dat_i, wbm_ack_i
   );

   modport slave (
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o,
      output wbm_dat_i, wbm_ack_i
   );
endinterface

// File: rtl/accel_job_master.sv
// Wishbone master that configures the matrix accelerator, streams A and B in, fires GO and streams C out.
// Optional ack timeout abort: define ACCEL_ACK_TIMEOUT_EN.
module accel_job_master #(
   parameter logic [31:0] CTRL_BASE      = 32'h3200_0000,
   parameter logic [31:0] RESULT_BASE    = 32'h3200_1000,
   parameter int          TYPE_BW        = 16,
   parameter int          DIM_MAX        = 16,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   accel_job_master_if.master        bus,
   input  logic                      start,
   input  logic [31:0]               op,
   input  logic [4:0]                dim,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [TYPE_BW-1:0] in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [TYPE_BW-1:0] out_data,
   output logic                      busy,
   output logic                      done,
   output logic                      error
);

   typedef enum logic [2:0] {IDLE, CFG, LOAD_A, LOAD_B, GO, READ_C, WAIT_OUT, FINISH} state_t;

   state_t      state;
   logic [31:0] op_q;
   logic [4:0]  n;
   logic [8:0]  nn;
   logic [8:0]  idx;
   logic [2:0]  cfg_idx;

   logic        acked;
   logic        last_elem;
   logic        dim_ok;
   logic        issue;
   logic        req_we;
   logic [31:0] req_adr;
   logic [31:0] req_dat;
   logic [31:0] elem_word;
   logic [31:0] b_base;
   logic        unused_hi;

   // An ack only counts while our strobe is up.
   assign acked     = bus.wbm_stb_o && bus.wbm_ack_i;
   assign last_elem = (idx == nn - 9'd1);
   assign dim_ok    = (dim != 5'd0) && ({27'd0, dim} <= DIM_MAX);
   assign in_ready  = ((state == LOAD_A) || (state == LOAD_B)) && !bus.wbm_cyc_o;
   assign elem_word = {{(32-TYPE_BW){in_data[TYPE_BW-1]}}, in_data};
   assign b_base    = CTRL_BASE + 32'd24 + {21'd0, nn, 2'b00};
   assign unused_hi = ^bus.wbm_dat_i[31:TYPE_BW];

   assign issue = !bus.wbm_cyc_o &&
                  ((state == CFG) || (state == GO) || (state == READ_C) ||
                   (((state == LOAD_A) || (state == LOAD_B)) && in_valid));

   always_comb begin
      req_we  = 1'b1;
      req_adr = CTRL_BASE;
      req_dat = '0;
      case (state)
         CFG: begin
            req_adr = CTRL_BASE + {27'd0, cfg_idx, 2'b00};
            req_dat = (cfg_idx == 3'd0) ? op_q : {27'd0, n};
         end
         LOAD_A: begin
            req_adr = CTRL_BASE + 32'd24 + {21'd0, idx, 2'b00};
            req_dat = elem_word;
         end
         LOAD_B: begin
            req_adr = b_base + {21'd0, idx, 2'b00};
            req_dat = elem_word;
         end
         GO: begin
            req_adr = CTRL_BASE + 32'd20;
            req_dat = 32'hFFFF_FFFF;
         end
         READ_C: begin
            req_we  = 1'b0;
            req_adr = RESULT_BASE + {21'd0, idx, 2'b00};
         end
         default: ;
      endcase
   end

`ifdef ACCEL_ACK_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0] tmo_cnt;
`endif

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state         <= IDLE;
         op_q          <= '0;
         n             <= '0;
         nn            <= '0;
         idx           <= '0;
         cfg_idx       <= '0;
         bus.wbm_cyc_o <= 1'b0;
         bus.wbm_stb_o <= 1'b0;
         bus.wbm_we_o  <= 1'b0;
         bus.wbm_adr_o <= '0;
         bus.wbm_dat_o <= '0;
         out_valid     <= 1'b0;
         out_data      <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
`ifdef ACCEL_ACK_TIMEOUT_EN
         tmo_cnt       <= '0;
`endif
      end else begin
         done <= 1'b0;
         // Drop the cycle on ack; a new one can only start after a full idle cycle.
         if (acked) begin
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
         end else if (issue) begin
            bus.wbm_cyc_o <= 1'b1;
            bus.wbm_stb_o <= 1'b1;
            bus.wbm_we_o  <= req_we;
            bus.wbm_adr_o <= req_adr;
            bus.wbm_dat_o <= req_dat;
         end

         case (state)
            IDLE: if (start) begin
               if (dim_ok) begin
                  op_q    <= op;
                  n       <= dim;
                  nn      <= 9'(dim) * 9'(dim);
                  cfg_idx <= '0;
                  error   <= 1'b0;
                  busy    <= 1'b1;
                  state   <= CFG;
               end else begin
                  error <= 1'b1;
               end
            end
            CFG: if (acked) begin
               cfg_idx <= cfg_idx + 3'd1;
               if (cfg_idx == 3'd4) begin
                  idx   <= '0;
                  state <= LOAD_A;
               end
            end
            LOAD_A: if (acked) begin
               if (last_elem) begin
                  idx   <= '0;
                  state <= LOAD_B;
               end else begin
                  idx <= idx + 9'd1;
               end
            end
            LOAD_B: if (acked) begin
               if (last_elem) begin
                  idx   <= '0;
                  state <= GO;
               end else begin
                  idx <= idx + 9'd1;
               end
            end
            GO: if (acked) begin
               idx   <= '0;
               state <= READ_C;
            end
            READ_C: if (acked) begin
               out_data  <= bus.wbm_dat_i[TYPE_BW-1:0];
               out_valid <= 1'b1;
               state     <= WAIT_OUT;
            end
            WAIT_OUT: if (out_ready) begin
               out_valid <= 1'b0;
               if (last_elem) begin
                  state <= FINISH;
               end else begin
                  idx   <= idx + 9'd1;
                  state <= READ_C;
               end
            end
            FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase

`ifdef ACCEL_ACK_TIMEOUT_EN
         // Abort the whole job if the slave stalls one transaction too long.
         if (bus.wbm_stb_o && !bus.wbm_ack_i) begin
            if (tmo_cnt == TMO_LAST) begin
               bus.wbm_cyc_o <= 1'b0;
               bus.wbm_stb_o <= 1'b0;
               out_valid     <= 1'b0;
               error         <= 1'b1;
               done          <= 1'b1;
               busy          <= 1'b0;
               tmo_cnt       <= '0;
               state         <= IDLE;
            end else begin
               tmo_cnt <= tmo_cnt + 1'b1;
            end
         end else begin
            tmo_cnt <= '0;
         end
`endif
      end
   end

endmodule
